// File: rtl/rev32_sequencer_pkg.sv
// Shared definitions for the time-shared 32-bit bit/byte reversal unit.
package rev32_sequencer_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned LANE_W    = 8;
    localparam int unsigned NUM_LANES = DATA_W / LANE_W;

    typedef enum logic [1:0] {
        OP_REV32 = 2'b00,
        OP_REVB  = 2'b01,
        OP_BSWAP = 2'b10,
        OP_PASS  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/rev32_sequencer_reverser8.sv
// Combinational 8-bit bit reverser shared across the four operand lanes.
module Reverser8 (
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);

    always_comb begin
        o_data = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            o_data[i] = i_data[7-i];
        end
    end

endmodule

// File: rtl/rev32_sequencer.sv
// Multi-cycle 32-bit reversal unit: one byte per cycle through a single
// Reverser8 for REV32/REVB, single-cycle load for BSWAP/PASS.
module rev32_sequencer
    import rev32_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_zero,
    output logic        busy
);

    state_t      r_state;
    op_t         r_op;
    logic [1:0]  r_k;
    logic [31:0] r_src;
    logic [31:0] r_res;

    logic [7:0]  w_lane_in;
    logic [7:0]  w_lane_out;
    logic [1:0]  w_dst;
    logic [31:0] w_run_res;

    always_comb begin
        w_lane_in = '0;
        for (int unsigned b = 0; b < NUM_LANES; b++) begin
            if (b == 32'(r_k)) begin
                w_lane_in = r_src[b*LANE_W +: LANE_W];
            end
        end
    end

    Reverser8 u_rev8 (
        .i_data (w_lane_in),
        .o_data (w_lane_out)
    );

    // REV32 mirrors byte position as well as bit order; REVB keeps position.
    assign w_dst = (r_op == OP_REV32) ? (2'd3 - r_k) : r_k;

    always_comb begin
        w_run_res = r_res;
        for (int unsigned b = 0; b < NUM_LANES; b++) begin
            if (b == 32'(w_dst)) begin
                w_run_res[b*LANE_W +: LANE_W] = w_lane_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_REV32;
            r_k     <= '0;
            r_src   <= '0;
            r_res   <= '0;
        end else if (flush) begin
            // Abort keeps res; only the sequencing state is dropped.
            r_state <= ST_IDLE;
            r_k     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_src <= in_data;
                        r_op  <= op_t'(in_op);
                        r_k   <= '0;
                        case (op_t'(in_op))
                            OP_BSWAP: begin
                                r_res   <= byte_swap(in_data);
                                r_state <= ST_DONE;
                            end
                            OP_PASS: begin
                                r_res   <= in_data;
                                r_state <= ST_DONE;
                            end
                            default: begin
                                r_res   <= '0;
                                r_state <= ST_RUN;
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    r_res <= w_run_res;
                    if (r_k == 2'd3) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_k <= r_k + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = rst_n && (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_data  = r_res;
    assign out_zero  = (r_res == '0);
    assign busy      = (r_state != ST_IDLE);

endmodule
